pipe_stage_reg: RTL

Parametrised, flushable pipeline stage register with a valid/ready handshake. It carries one DATA_W-bit payload per beat between two pipeline stages, e.g. MEM→WB, EX→MEM or ID→EX. Over a plain clocked register it adds back-pressure, bubble tracking, flush and a synchronous reset. An optional 2-entry skid buffer breaks the combinational ready path.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_stage_reg_skid.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline payload types and widths for the inter-stage registers.
package pipe_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_NUM_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]      mem_out;
    logic [REG_NUM_W-1:0] rd_num;
    logic [XLEN-1:0]      alu_out;
    logic                 op_type;
  } mem_wb_t;

  typedef struct packed {
    logic [XLEN-1:0]      alu_out;
    logic [XLEN-1:0]      store_data;
    logic [REG_NUM_W-1:0] rd_num;
    logic                 mem_rd;
    logic                 mem_wr;
    logic                 op_type;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;
    logic [XLEN-1:0]      imm;
    logic [REG_NUM_W-1:0] rd_num;
    logic [3:0]           alu_op;
    logic                 mem_rd;
    logic                 mem_wr;
    logic                 op_type;
  } id_ex_t;

  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);

endpackage

// File: rtl/pipe_stage_reg_skid.sv
// Single skid entry (valid + payload) behind the main stage register.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_WB_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end else if (i_shift) begin
        r_valid <= 1'b0;
      end
      if (i_load && !i_flush) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flushable valid/ready pipeline stage register; define PIPE_STAGE_REG_SKID_EN to add a
// 2-entry skid buffer with a registered up_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = MEM_WB_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_up_valid,
  input  logic [DATA_W-1:0] i_up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              i_dn_ready,
  output logic [1:0]        occupancy
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_acc;
  logic              w_send;
  logic              w_main_load;
  logic [DATA_W-1:0] w_main_din;
  logic              w_main_vld_d;

  assign w_acc  = i_up_valid & up_ready;
  assign w_send = r_valid & i_dn_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_skid_load;
  logic              w_skid_shift;

  pipe_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_load  (w_skid_load),
    .i_shift (w_skid_shift),
    .i_data  (i_up_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  // Skid valid only ever coexists with main valid, so it alone marks FULL.
  assign up_ready  = i_rst_n & ~w_skid_valid;
  assign occupancy = {w_skid_valid, r_valid & ~w_skid_valid};

  always_comb begin
    w_skid_load  = w_acc & r_valid & ~w_send;
    w_skid_shift = w_send & w_skid_valid;
    w_main_load  = w_skid_shift | (w_acc & (~r_valid | w_send));
    w_main_din   = w_skid_shift ? w_skid_data : i_up_data;
  end
`else
  assign up_ready  = i_rst_n & (~r_valid | i_dn_ready);
  assign occupancy = {1'b0, r_valid};

  always_comb begin
    w_main_load = w_acc;
    w_main_din  = i_up_data;
  end
`endif

  assign w_main_vld_d = w_main_load | (r_valid & ~w_send);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VAL;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_main_vld_d;
      if (w_main_load) begin
        r_data <= w_main_din;
      end
    end
  end

  assign dn_valid = r_valid;
  assign dn_data  = r_data;

endmodule
